envelope_follower: RTL and testbench
====================================

# envelope_follower

Measures the amplitude envelope of a signed audio stream and derives a note gate from it. Each valid sample is full-wave rectified, then smoothed by a one-pole attack/release filter. A hysteretic gate state machine with a hold timer turns the smoothed level into `gate_out`. This is the analysis-side counterpart of the envelope generator: `gate_out` is suitable for driving a `play` input, and `env_out` for metering, ducking or sidechain use.

## Interface
- `DATA_WIDTH`, 32: sample width (signed in, unsigned envelope out)
- `SHIFT_WIDTH`, 5: width of attack/release shift controls
- `HOLD_WIDTH`, 16: width of hold-length control
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  asynchronous, active-low reset
- `data_in`  in  DATA_WIDTH  signed audio sample
- `valid_in`  in  1  sample strobe; back-to-back allowed
- `attack_shift`  in  SHIFT_WIDTH  rise coefficient, step = diff >> attack_shift
- `release_shift`  in  SHIFT_WIDTH  fall coefficient, step = diff >> release_shift
- `open_thresh`  in  DATA_WIDTH  gate opens when env ≥ this
- `close_thresh`  in  DATA_WIDTH  gate starts hold when env < this
- `hold_len`  in  HOLD_WIDTH  samples gate stays open after falling below close_thresh
- `env_out`  out  DATA_WIDTH  unsigned smoothed envelope
- `env_valid`  out  1  one-cycle strobe, env_out updated
- `gate_out`  out  1  gate, high in OPEN/HOLD

## Operation
- Stage 1 (rectify, on valid_in): `rect = |data_in|`; the most negative input (−2^(DW−1)) saturates to 2^(DW−1)−1. Values are registered with a valid bit.
- Stage 2 (smooth, on stage-1 valid): with `env` the current `env_out`:
  - if rect > env: env += max(1, (rect−env) >> attack_shift)
  - if rect < env: env −= max(1, (env−rect) >> release_shift)
  - if equal: unchanged.
  - A minimum step of 1 guarantees convergence. Shifts ≥ DATA_WIDTH yield a step of exactly 1.
  - Shift 0 gives env = rect exactly. The result never overshoots rect.
- Gate FSM, evaluated only on `env_valid` cycles, using the registered `env_out`:
  - CLOSED → OPEN when env ≥ open_thresh.
  - OPEN → HOLD when env < close_thresh; the hold counter is loaded with hold_len−1. If hold_len = 0, go directly to CLOSED.
  - HOLD → OPEN when env ≥ open_thresh. This has priority over expiry.
  - HOLD → CLOSED when the counter = 0 and env < open_thresh.
  - Otherwise the counter decrements.
- Controls are sampled at their point of use. A change takes effect on the next sample processed by that stage.
- If close_thresh > open_thresh, behaviour still follows the rules above; no check is made.

## Timing
- Throughput: 1 sample/cycle.
- Latency: valid_in at cycle t → env_out/env_valid at t+2 → gate_out reflects that sample at t+3.
- When valid_in is low, no stage advances its state: env, counter and FSM hold. The valid bits drop accordingly.
- Reset (async assert, synchronous-safe deassert): env_out=0, env_valid=0, gate_out=0, FSM=CLOSED, counter=0, pipeline valids=0.
- Reset mid-stream discards in-flight samples. The first env_valid after reset release corresponds to the first valid_in sampled after release, at release+2 minimum.
- Hold duration: gate_out stays high for exactly hold_len env_valid strobes after the strobe that entered HOLD, then falls on the following cycle.

## Structure
- Shared audio package: `gate_state_t` enum {CLOSED, OPEN, HOLD}; constants for default shift and hold values.
- One sub-module, `envelope_smoother`: rectify plus one-pole filter, with valid-in/valid-out. The gate FSM and hold counter live in the top module.

## Test plan
- Reset mid-operation: drive rst low while gate_out=1 and env_out=1000 → env_out=0, gate_out=0, env_valid=0 within the same cycle. After release, the first env_valid arrives 2 cycles after the first valid_in.
- Attack smoothing: attack_shift=2, env=0, constant data_in=+1000 each cycle → env_out = 250, 437, 577, … Each value appears 2 cycles after its sample and never exceeds 1000.
- Rectify saturation: attack_shift=0, data_in=−2^31 → env_out=2^31−1. data_in=−7 → env_out=7.
- Minimum step: attack_shift=31, env=0, data_in=5 → env_out increments 1, 2, 3, 4, 5, then stays at 5.
- Gate with hold: open=500, close=300, hold_len=3, shifts=0. Input 1000 for 4 samples → gate_out=1 at t+3. Then input 0 → gate_out stays high 3 more strobes, then 0.
- Hold retrigger and zero hold: during HOLD, input 600 → FSM returns to OPEN and gate_out stays 1. With hold_len=0, a drop below 300 → gate_out=0 on the very next cycle after that strobe.

Source files
------------

// File: rtl/envelope_follower_pkg.sv
// Shared audio definitions: gate states and default control values.
package envelope_follower_pkg;

  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    OPEN   = 2'd1,
    HOLD   = 2'd2
  } gate_state_t;

  localparam int DEFAULT_ATTACK_SHIFT  = 2;
  localparam int DEFAULT_RELEASE_SHIFT = 6;
  localparam int DEFAULT_HOLD_LEN      = 256;

endpackage

// File: rtl/envelope_smoother.sv
// Full-wave rectifier followed by a one-pole attack/release smoother.
// Two register stages: rectified sample, then smoothed envelope.
module envelope_smoother #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_valid,
  input  logic [SHIFT_WIDTH-1:0] i_attack_shift,
  input  logic [SHIFT_WIDTH-1:0] i_release_shift,
  output logic [DATA_WIDTH-1:0]  o_env,
  output logic                   o_env_valid
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_POS  = ~MOST_NEG;
  localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] w_rect;
  logic [DATA_WIDTH-1:0] r_rect;
  logic                  r_rect_valid;
  logic [DATA_WIDTH-1:0] r_env;
  logic                  r_env_valid;

  logic [DATA_WIDTH-1:0] w_rise_shr;
  logic [DATA_WIDTH-1:0] w_fall_shr;
  logic [DATA_WIDTH-1:0] w_rise_step;
  logic [DATA_WIDTH-1:0] w_fall_step;
  logic [DATA_WIDTH-1:0] w_env_next;

  // Absolute value; the most negative code has no positive twin, so it saturates.
  always_comb begin
    // NOTE: assign a default before any branch so the block can never infer a latch.
    w_rect = i_data;
    if (i_data[DATA_WIDTH-1]) begin
      if (i_data == MOST_NEG) w_rect = MAX_POS;
      else                    w_rect = ~i_data + ONE;
    end
  end

  // Stage 1: capture the rectified sample; the valid bit follows valid_in every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) begin
      r_rect       <= '0;
      r_rect_valid <= 1'b0;
    end else begin
      r_rect_valid <= i_valid;
      if (i_valid) r_rect <= w_rect;
    end
  end

  // Step size: shifted difference, floored at 1 so the envelope always converges.
  // A shift of zero yields the full difference, so the envelope lands exactly on rect.
  always_comb begin
    w_rise_shr  = (r_rect - r_env) >> i_attack_shift;
    w_fall_shr  = (r_env - r_rect) >> i_release_shift;
    w_rise_step = (w_rise_shr == '0) ? ONE : w_rise_shr;
    w_fall_step = (w_fall_shr == '0) ? ONE : w_fall_shr;
    w_env_next  = r_env;
    if (r_rect > r_env)      w_env_next = r_env + w_rise_step;
    else if (r_rect < r_env) w_env_next = r_env - w_fall_step;
  end

  // Stage 2: advance the envelope only when a rectified sample is present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_env       <= '0;
      r_env_valid <= 1'b0;
    end else begin
      r_env_valid <= r_rect_valid;
      if (r_rect_valid) r_env <= w_env_next;
    end
  end

  assign o_env       = r_env;
  assign o_env_valid = r_env_valid;

endmodule

// File: rtl/envelope_follower.sv
// Envelope follower: smoothed amplitude plus a hysteretic, hold-timed note gate.
module envelope_follower
  import envelope_follower_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 5,
  parameter int HOLD_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   valid_in,
  input  logic [SHIFT_WIDTH-1:0] attack_shift,
  input  logic [SHIFT_WIDTH-1:0] release_shift,
  input  logic [DATA_WIDTH-1:0]  open_thresh,
  input  logic [DATA_WIDTH-1:0]  close_thresh,
  input  logic [HOLD_WIDTH-1:0]  hold_len,
  output logic [DATA_WIDTH-1:0]  env_out,
  output logic                   env_valid,
  output logic                   gate_out
);

  localparam logic [HOLD_WIDTH-1:0] HOLD_ONE = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] w_env;
  logic                  w_env_valid;
  gate_state_t           r_state;
  gate_state_t           w_state_next;
  logic [HOLD_WIDTH-1:0] r_hold_cnt;
  logic [HOLD_WIDTH-1:0] w_hold_cnt_next;

  envelope_smoother #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_smoother (
    .clk             (clk),
    .rst_n           (rst),
    .i_data          (data_in),
    .i_valid         (valid_in),
    .i_attack_shift  (attack_shift),
    .i_release_shift (release_shift),
    .o_env           (w_env),
    .o_env_valid     (w_env_valid)
  );

  // Gate state register and hold counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= CLOSED;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_cnt_next;
    end
  end

  // Next-state logic, evaluated only on envelope strobes using the registered envelope.
  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt;
    if (w_env_valid) begin
      unique case (r_state)
        CLOSED: begin
          if (w_env >= open_thresh) w_state_next = OPEN;
        end
        OPEN: begin
          if (w_env < close_thresh) begin
            if (hold_len == '0) begin
              w_state_next = CLOSED;
            end else begin
              w_state_next    = HOLD;
              w_hold_cnt_next = hold_len - HOLD_ONE;
            end
          end
        end
        HOLD: begin
          // Retrigger wins over expiry.
          if (w_env >= open_thresh)   w_state_next = OPEN;
          else if (r_hold_cnt == '0)  w_state_next = CLOSED;
          else                        w_hold_cnt_next = r_hold_cnt - HOLD_ONE;
        end
        default: w_state_next = CLOSED;
      endcase
    end
  end

  assign env_out   = w_env;
  assign env_valid = w_env_valid;
  assign gate_out  = (r_state != CLOSED);

endmodule

// File: tb/tb_envelope_follower.sv
// Scoreboard bench for envelope_follower: driver predicts with a plain-arithmetic
// model, monitor pops expectations on each env_valid strobe.
module tb_envelope_follower;

  localparam int DW = 32;
  localparam int SW = 5;
  localparam int HW = 16;
  localparam longint MAXPOS = 64'd2147483647;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic [SW-1:0] attack_shift;
  logic [SW-1:0] release_shift;
  logic [DW-1:0] open_thresh;
  logic [DW-1:0] close_thresh;
  logic [HW-1:0] hold_len;
  logic [DW-1:0] env_out;
  logic          env_valid;
  logic          gate_out;

  envelope_follower #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW), .HOLD_WIDTH(HW)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .attack_shift  (attack_shift),
    .release_shift (release_shift),
    .open_thresh   (open_thresh),
    .close_thresh  (close_thresh),
    .hold_len      (hold_len),
    .env_out       (env_out),
    .env_valid     (env_valid),
    .gate_out      (gate_out)
  );

  always #5 clk = ~clk;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint env;
    bit     gate;
    longint stamp;
  } exp_t;

  exp_t   sb[$];
  longint env_log[$];

  // Reference model state: envelope as a plain number, gate as open/holding flags.
  longint m_env;
  bit     m_open;
  bit     m_holding;
  int     m_left;

  bit gate_pending = 1'b0;
  bit gate_exp     = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint rect_of(input logic [DW-1:0] d);
    longint v;
    v = longint'($signed(d));
    if (v < 0) v = -v;
    if (v > MAXPOS) v = MAXPOS;
    return v;
  endfunction

  task automatic model_reset();
    m_env = 0; m_open = 0; m_holding = 0; m_left = 0;
  endtask

  task automatic model_sample(input logic [DW-1:0] d, output exp_t e);
    longint r, diff, step;
    r = rect_of(d);
    if (r > m_env) begin
      diff = r - m_env;
      step = (int'(attack_shift) >= DW) ? 1 : (diff >>> attack_shift);
      if (step < 1) step = 1;
      m_env = m_env + step;
    end else if (r < m_env) begin
      diff = m_env - r;
      step = (int'(release_shift) >= DW) ? 1 : (diff >>> release_shift);
      if (step < 1) step = 1;
      m_env = m_env - step;
    end
    if (m_open) begin
      if (m_env < longint'(close_thresh)) begin
        m_open = 0;
        if (hold_len != 0) begin
          m_holding = 1;
          m_left    = int'(hold_len);
        end
      end
    end else if (m_holding) begin
      if (m_env >= longint'(open_thresh)) begin
        m_holding = 0;
        m_open    = 1;
      end else begin
        m_left--;
        if (m_left == 0) m_holding = 0;
      end
    end else if (m_env >= longint'(open_thresh)) begin
      m_open = 1;
    end
    e.env   = m_env;
    e.gate  = m_open || m_holding;
    e.stamp = cyc;
  endtask

  task automatic send(input logic [DW-1:0] d);
    exp_t e;
    @(posedge clk); #1;
    data_in  = d;
    valid_in = 1'b1;
    model_sample(d, e);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      data_in  = $urandom;
    end
  endtask

  task automatic drain();
    int budget = 50;
    idle(1);
    while ((sb.size() != 0 || gate_pending) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d expectations still pending", sb.size());
    end
  endtask

  task automatic set_ctrl(input int att, input int rel, input longint op, input longint cl, input int hl);
    attack_shift  = SW'(att);
    release_shift = SW'(rel);
    open_thresh   = DW'(op);
    close_thresh  = DW'(cl);
    hold_len      = HW'(hl);
  endtask

  // Monitor: on every strobe, compare envelope and latency; gate is compared one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      gate_pending = 1'b0;
    end else begin
      if (gate_pending) begin
        check("gate_out", longint'(gate_out), longint'(gate_exp));
        gate_pending = 1'b0;
      end
      if (env_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_env_valid: env_out=%0d with no sample outstanding", env_out);
        end else begin
          e = sb.pop_front();
          check("env_out", longint'(env_out), e.env);
          check("latency", cyc - e.stamp, 2);
          env_log.push_back(longint'(env_out));
          gate_exp     = e.gate;
          gate_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint mx;
    int     n;
    rst = 1'b0;
    valid_in = 1'b0;
    data_in = '0;
    set_ctrl(2, 2, 64'hFFFF_FFFF, 0, 3);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_env_out", longint'(env_out), 0);
    check("reset_env_valid", longint'(env_valid), 0);
    check("reset_gate_out", longint'(gate_out), 0);
    rst = 1'b1;
    idle(3);
    check("post_release_env_valid", longint'(env_valid), 0);

    // Attack smoothing from zero towards a constant 1000.
    env_log.delete();
    repeat (8) send(DW'(1000));
    drain();
    check("attack_1", env_log[0], 250);
    check("attack_2", env_log[1], 437);
    check("attack_3", env_log[2], 577);
    mx = 0;
    foreach (env_log[i]) if (env_log[i] > mx) mx = env_log[i];
    check("attack_no_overshoot", longint'(mx <= 1000), 1);

    // Rectify saturation and exact tracking with zero shifts.
    set_ctrl(0, 0, 64'hFFFF_FFFF, 0, 3);
    env_log.delete();
    send(32'h8000_0000);
    send(-32'sd7);
    send(DW'(0));
    drain();
    check("sat_most_negative", env_log[0], MAXPOS);
    check("rect_minus7", env_log[1], 7);

    // Minimum step of one with a large shift.
    set_ctrl(31, 0, 64'hFFFF_FFFF, 0, 3);
    env_log.delete();
    repeat (7) send(DW'(5));
    drain();
    for (int i = 0; i < 7; i++) check("min_step", env_log[i], (i < 5) ? i + 1 : 5);

    // Gate with hold.
    set_ctrl(0, 0, 500, 300, 3);
    send(DW'(0));
    drain();
    repeat (4) send(DW'(1000));
    drain();
    check("gate_open", longint'(gate_out), 1);
    repeat (3) send(DW'(0));
    drain();
    check("gate_in_hold", longint'(gate_out), 1);
    send(DW'(0));
    drain();
    check("gate_hold_expired", longint'(gate_out), 0);

    // Retrigger from HOLD, then zero-length hold.
    send(DW'(1000));
    send(DW'(0));
    send(DW'(600));
    drain();
    check("gate_retrigger", longint'(gate_out), 1);
    hold_len = '0;
    send(DW'(0));
    drain();
    check("gate_zero_hold", longint'(gate_out), 0);

    // Randomised batches; controls change only while the pipeline is empty.
    for (int b = 0; b < 6; b++) begin
      set_ctrl(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31),
               ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31),
               $urandom_range(0, 2000), $urandom_range(0, 2000), $urandom_range(0, 6));
      n = 0;
      while (n < 200) begin
        if ($urandom_range(0, 3) == 0) begin
          idle(1);
        end else begin
          if ($urandom_range(0, 9) == 0) send($urandom);
          else send(DW'($signed($urandom_range(0, 6000)) - 3000));
          n++;
        end
      end
      drain();
    end

    // Reset mid-operation with a sample in flight.
    set_ctrl(0, 0, 500, 300, 5);
    repeat (3) send(DW'(1000));
    drain();
    check("pre_reset_env", longint'(env_out), 1000);
    check("pre_reset_gate", longint'(gate_out), 1);
    send(DW'(5));
    @(posedge clk); #1;
    valid_in = 1'b0;
    rst = 1'b0;
    #1;
    check("midreset_env_out", longint'(env_out), 0);
    check("midreset_gate_out", longint'(gate_out), 0);
    check("midreset_env_valid", longint'(env_valid), 0);
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(4);
    send(DW'(1234));
    drain();
    check("post_reset_env", longint'(env_out), 1234);
    check("post_reset_gate", longint'(gate_out), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
